// File: rtl/prog_ram_loader_pkg.sv
// prog_ram_loader_pkg: FSM state type and encoding shared by the loader files
package prog_ram_loader_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    RB_FETCH = 2'd2,
    RB_SEND  = 2'd3
  } state_e;
endpackage

// File: rtl/prog_ram_loader_if.sv
// prog_ram_loader_if: host load/readback stream and CPU memory port bundle
interface prog_ram_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  load_start;
  logic                  ld_abort;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  logic                  ld_busy;
  logic                  ld_done;
  logic [ADDR_WIDTH:0]   ld_count;
  logic [DATA_WIDTH-1:0] checksum;
  logic                  rb_start;
  logic                  rb_valid;
  logic [DATA_WIDTH-1:0] rb_data;
  logic                  rb_ready;
  logic                  cpu_hold;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  modport master (
    output load_start, ld_abort, ld_valid, ld_data, rb_start, rb_ready, cpu_addr, cpu_we, cpu_wdata,
    input  ld_ready, ld_busy, ld_done, ld_count, checksum, rb_valid, rb_data, cpu_hold, cpu_rdata
  );
  modport slave (
    input  load_start, ld_abort, ld_valid, ld_data, rb_start, rb_ready, cpu_addr, cpu_we, cpu_wdata,
    output ld_ready, ld_busy, ld_done, ld_count, checksum, rb_valid, rb_data, cpu_hold, cpu_rdata
  );
endinterface

// File: rtl/prog_ram_loader_sp_ram.sv
// sp_ram: single-port synchronous RAM, read-first registered output, array not reset
module sp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  // array write; left without reset so it can map onto block RAM
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  // output register samples the old word, giving read-first behaviour
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata_q <= '0;
    else rdata_q <= mem_q[addr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/prog_ram_loader.sv
// prog_ram_loader: program RAM with streaming loader, readback port and CPU hold
module prog_ram_loader
  import prog_ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LOAD_WORDS = 2**ADDR_WIDTH
) (
  input logic               clk,
  input logic               reset,
  prog_ram_loader_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(LOAD_WORDS-1);
  if (LOAD_WORDS > DEPTH || LOAD_WORDS == 0) begin : g_bad_load_words
    $error("prog_ram_loader: LOAD_WORDS must be within 1..DEPTH");
  end
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  done_q, done_d;
  logic                  hold_q;
  logic [DATA_WIDTH-1:0] rd_hold_q;
  logic                  load_we;
  logic [DATA_WIDTH-1:0] ram_q;
  // next state, loader counters and checksum
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    done_d  = done_q;
    load_we = 1'b0;
    case (state_q)
      IDLE:
        if (bus.load_start) begin
          state_d = LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
        end else if (bus.rb_start) begin
          state_d = RB_FETCH;
          addr_d  = '0;
        end
      LOAD:
        if (bus.ld_abort) state_d = IDLE;
        else if (bus.ld_valid) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          sum_d   = sum_q + bus.ld_data;
          addr_d  = cnt_q == LAST ? addr_q : addr_q + 1'b1;
          state_d = cnt_q == LAST ? IDLE : LOAD;
          done_d  = cnt_q == LAST;
        end
      RB_FETCH: state_d = RB_SEND;
      RB_SEND:
        if (bus.rb_ready) begin
          state_d = addr_q == '1 ? IDLE : RB_FETCH;
          addr_d  = addr_q == '1 ? addr_q : addr_q + 1'b1;
        end
    endcase
  end
  // state registers; cpu_hold is registered from the next state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      done_q    <= 1'b0;
      hold_q    <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      done_q    <= done_d;
      hold_q    <= state_d != IDLE;
      rd_hold_q <= hold_q ? rd_hold_q : ram_q;
    end
  sp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (load_we | (~hold_q & bus.cpu_we)),
    .addr_i  (hold_q ? addr_q : bus.cpu_addr),
    .wdata_i (hold_q ? bus.ld_data : bus.cpu_wdata),
    .rdata_o (ram_q)
  );
  assign bus.ld_ready  = state_q == LOAD;
  assign bus.ld_busy   = state_q == LOAD;
  assign bus.ld_done   = done_q;
  assign bus.ld_count  = cnt_q;
  assign bus.checksum  = sum_q;
  assign bus.rb_valid  = state_q == RB_SEND;
  assign bus.rb_data   = state_q == RB_SEND ? ram_q : '0;
  assign bus.cpu_hold  = hold_q;
  assign bus.cpu_rdata = hold_q ? rd_hold_q : ram_q;
endmodule

// File: tb/tb_prog_ram_loader.sv
// tb_prog_ram_loader: directed, table-driven bench for prog_ram_loader
module tb_prog_ram_loader;
  localparam int DW = 8;
  localparam int AW = 4;
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t vecs [21];
  always #5 clk = ~clk;
  prog_ram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  prog_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_WORDS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.cpu_addr  = vecs[i].addr;
      bus.cpu_we    = vecs[i].we;
      bus.cpu_wdata = vecs[i].wdata;
      tick();
      check($sformatf("cpu_vec%0d", i), bus.cpu_rdata, vecs[i].exp);
    end
    bus.cpu_we = 1'b0;
  endtask
  task automatic load_n(input int n);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = DW'(8'h11 * i);
      tick();
    end
    bus.ld_valid = 1'b0;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_ld_ready"}, bus.ld_ready, 0);
    check({tag, "_ld_busy"}, bus.ld_busy, 0);
    check({tag, "_ld_done"}, bus.ld_done, 0);
    check({tag, "_ld_count"}, bus.ld_count, 0);
    check({tag, "_checksum"}, bus.checksum, 0);
    check({tag, "_rb_valid"}, bus.rb_valid, 0);
    check({tag, "_rb_data"}, bus.rb_data, 0);
    check({tag, "_cpu_hold"}, bus.cpu_hold, 0);
    check({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int cyc;
    int n;
    int budget;
    bit stable;
    logic [DW-1:0] held;
    vecs[0]  = '{4'd3,  1'b0, 8'h00, 8'h33};
    vecs[1]  = '{4'd15, 1'b0, 8'h00, 8'hFF};
    vecs[2]  = '{4'd2,  1'b1, 8'hA5, 8'h22};
    vecs[3]  = '{4'd2,  1'b0, 8'h00, 8'hA5};
    vecs[4]  = '{4'd0,  1'b1, 8'hC0, 8'h00};
    vecs[5]  = '{4'd1,  1'b1, 8'hC1, 8'h11};
    vecs[6]  = '{4'd2,  1'b1, 8'hC2, 8'hA5};
    vecs[7]  = '{4'd3,  1'b1, 8'hC3, 8'h33};
    vecs[8]  = '{4'd4,  1'b1, 8'hC4, 8'h44};
    vecs[9]  = '{4'd5,  1'b1, 8'hC5, 8'h55};
    vecs[10] = '{4'd5,  1'b0, 8'h00, 8'hC5};
    vecs[11] = '{4'd0,  1'b0, 8'h00, 8'h00};
    vecs[12] = '{4'd1,  1'b0, 8'h00, 8'h11};
    vecs[13] = '{4'd2,  1'b0, 8'h00, 8'h22};
    vecs[14] = '{4'd3,  1'b0, 8'h00, 8'h33};
    vecs[15] = '{4'd4,  1'b0, 8'h00, 8'h44};
    vecs[16] = '{4'd5,  1'b0, 8'h00, 8'hC5};
    vecs[17] = '{4'd5,  1'b0, 8'h00, 8'h55};
    vecs[18] = '{4'd2,  1'b0, 8'h00, 8'h22};
    vecs[19] = '{4'd0,  1'b0, 8'h00, 8'hAB};
    vecs[20] = '{4'd1,  1'b0, 8'h00, 8'hCD};
    bus.load_start = 0; bus.ld_abort = 0; bus.ld_valid = 0; bus.ld_data = 0;
    bus.rb_start = 0; bus.rb_ready = 0; bus.cpu_addr = 0; bus.cpu_we = 0; bus.cpu_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    // full load with ld_valid high; CPU write attempts must be ignored
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check("load_cpu_hold", bus.cpu_hold, 1);
    check("load_ready", bus.ld_ready, 1);
    bus.cpu_we = 1'b1; bus.cpu_addr = 4'd3; bus.cpu_wdata = 8'hEE;
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = DW'(8'h11 * i);
      tick();
      if (i == 14) begin
        check("load_done_early", bus.ld_done, 0);
        check("load_hold_mid", bus.cpu_hold, 1);
      end
    end
    bus.cpu_we = 1'b0;
    check("load_done", bus.ld_done, 1);
    check("load_count", bus.ld_count, 16);
    check("load_checksum", bus.checksum, 8'hF8);
    check("load_hold_off", bus.cpu_hold, 0);
    check("load_ready_off", bus.ld_ready, 0);
    bus.ld_data = 8'h77;
    tick();
    bus.ld_valid = 1'b0;
    check("load_no_extra", bus.ld_count, 16);
    cpu_run(0, 10);
    // abort after 5 words with a coincident handshake that must not be written
    load_n(5);
    bus.ld_abort = 1'b1; bus.ld_valid = 1'b1; bus.ld_data = 8'h99;
    tick();
    bus.ld_abort = 1'b0; bus.ld_valid = 1'b0;
    check("abort_done", bus.ld_done, 0);
    check("abort_count", bus.ld_count, 5);
    check("abort_checksum", bus.checksum, 8'hAA);
    check("abort_busy", bus.ld_busy, 0);
    check("abort_hold", bus.cpu_hold, 0);
    cpu_run(11, 16);
    // load with ld_valid toggling; a stray rb_start during load is ignored
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    cyc = 0;
    n = 0;
    while (bus.ld_busy && cyc < 40) begin
      bus.ld_valid = cyc[0];
      bus.ld_data  = bus.ld_valid ? DW'(8'h11 * n) : 8'hFF;
      if (bus.ld_valid && bus.ld_ready) n++;
      bus.rb_start = cyc == 3;
      tick();
      cyc++;
    end
    bus.ld_valid = 1'b0;
    bus.rb_start = 1'b0;
    check("toggle_cycles", cyc, 32);
    check("toggle_done", bus.ld_done, 1);
    check("toggle_count", bus.ld_count, 16);
    check("toggle_checksum", bus.checksum, 8'hF8);
    check("toggle_rb_ignored", bus.rb_valid, 0);
    cpu_run(17, 18);
    // readback with three stall cycles per word
    bus.rb_start = 1'b1;
    tick();
    bus.rb_start = 1'b0;
    check("rb_hold_on", bus.cpu_hold, 1);
    check("rb_fetch_invalid", bus.rb_valid, 0);
    for (int w = 0; w < 16; w++) begin
      budget = 0;
      while (!bus.rb_valid && budget < 4) begin
        tick();
        budget++;
      end
      check($sformatf("rb_valid%0d", w), bus.rb_valid, 1);
      check($sformatf("rb_data%0d", w), bus.rb_data, DW'(8'h11 * w));
      held = bus.rb_data;
      stable = 1'b1;
      repeat (3) begin
        tick();
        if (!bus.rb_valid || bus.rb_data !== held) stable = 1'b0;
      end
      check($sformatf("rb_stable%0d", w), stable, 1);
      bus.rb_ready = 1'b1;
      tick();
      bus.rb_ready = 1'b0;
    end
    check("rb_end_valid", bus.rb_valid, 0);
    check("rb_end_hold", bus.cpu_hold, 0);
    tick();
    check("rb_end_valid2", bus.rb_valid, 0);
    // simultaneous starts: load wins, readback is dropped
    bus.load_start = 1'b1; bus.rb_start = 1'b1;
    tick();
    bus.load_start = 1'b0; bus.rb_start = 1'b0;
    check("both_busy", bus.ld_busy, 1);
    check("both_done_cleared", bus.ld_done, 0);
    bus.ld_abort = 1'b1;
    tick();
    bus.ld_abort = 1'b0;
    check("both_count", bus.ld_count, 0);
    tick();
    check("both_no_rb", bus.rb_valid, 0);
    check("both_idle", bus.cpu_hold, 0);
    // asynchronous reset in the middle of a load
    load_n(7);
    check("prereset_count", bus.ld_count, 7);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("postreset_done", bus.ld_done, 0);
    check("postreset_busy", bus.ld_busy, 0);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 8'hAB;
    tick();
    bus.ld_data = 8'hCD;
    tick();
    bus.ld_valid = 1'b0; bus.ld_abort = 1'b1;
    tick();
    bus.ld_abort = 1'b0;
    check("reload_count", bus.ld_count, 2);
    check("reload_checksum", bus.checksum, 8'h78);
    cpu_run(19, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_ram_loader.md
Name: prog_ram_loader

Overview:
- Parametrised program RAM with a built-in streaming loader and readback port. It replaces simulation-only memory preload and dump with synthesizable hardware, so programs can be loaded on the FPGA.
- Sits between the host link (UART or debug bridge) and the CPU memory bus.
- While a load or readback is in progress, it holds the CPU in reset via cpu_hold.

Parameters:
DATA_WIDTH, 8, word width of RAM and of all data ports
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH is a localparam
LOAD_WORDS, 2**ADDR_WIDTH, words accepted per load; LOAD_WORDS > DEPTH or LOAD_WORDS == 0 is an elaboration error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_start  in  1  single-cycle pulse, begins a load at address 0
ld_abort  in  1  terminates an in-progress load
ld_valid  in  1  load word valid
ld_data  in  DATA_WIDTH  load word
ld_ready  out  1  loader accepts a word this cycle
ld_busy  out  1  load in progress
ld_done  out  1  sticky flag: last load completed fully
ld_count  out  ADDR_WIDTH+1  words accepted by the current or last load
checksum  out  DATA_WIDTH  sum of loaded words, modulo 2**DATA_WIDTH
rb_start  in  1  single-cycle pulse, begins readback of all DEPTH words
rb_valid  out  1  readback word valid
rb_data  out  DATA_WIDTH  readback word
rb_ready  in  1  consumer accepts the readback word
cpu_hold  out  1  high while loading or reading back; drives the CPU reset
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_we  in  1  CPU write enable
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_rdata  out  DATA_WIDTH  CPU read data, registered

Behaviour:
- Reset (reset low, asynchronous): all outputs are 0 and the FSM is in IDLE. RAM contents are not cleared.
- FSM states: IDLE, LOAD, RB_FETCH, RB_SEND.
- IDLE:
  - load_start: go to LOAD. Clear addr, ld_count and checksum; clear ld_done.
  - rb_start alone: go to RB_FETCH with addr = 0.
  - load_start and rb_start in the same cycle: load wins and rb_start is dropped.
- LOAD:
  - ld_ready = 1 and ld_busy = 1.
  - On ld_valid && ld_ready: write ld_data to RAM[addr], increment addr and ld_count, and add ld_data to checksum (truncating).
  - On the handshake that makes ld_count == LOAD_WORDS: next state is IDLE and ld_done is set in the same edge. No further word is accepted.
  - ld_abort: next state is IDLE and ld_done stays 0. ld_count and checksum keep their values. Words already written remain in RAM.
  - ld_abort takes priority over a coincident handshake; that word is not written.
  - Address never wraps.
- RB_FETCH: one cycle for the registered RAM read of RAM[addr]; next state is RB_SEND.
- RB_SEND:
  - rb_valid = 1 and rb_data = fetched word.
  - rb_data is held stable until rb_ready is seen.
  - On handshake: if addr == DEPTH-1, go to IDLE; otherwise increment addr and go to RB_FETCH.
  - Throughput is at most one word per 2 cycles.
- cpu_hold = 1 in every state except IDLE. It is registered, so it rises one cycle after load_start or rb_start.
- load_start and rb_start outside IDLE are ignored.
- CPU port:
  - Active only in IDLE; cpu_we is ignored while cpu_hold = 1.
  - Read latency is 1 cycle. A read and write to the same address in the same cycle is read-first: cpu_rdata shows the old data.
  - While cpu_hold = 1, cpu_rdata holds its last value.
- RAM address mux: the loader/readback address is used when cpu_hold = 1, otherwise cpu_addr.
- Reset asserted mid-operation: outputs go to 0 immediately. A partial load leaves ld_done = 0 after reset.

Decomposition:
- Shared package prog_ram_loader_pkg holds the FSM state enum typedef and the state encoding constants.
- One sub-module, sp_ram: single-port synchronous RAM with parametrised DATA_WIDTH/ADDR_WIDTH, registered read-first output and no reset on the array.
- prog_ram_loader contains the FSM, counters, checksum and address/write muxing.

Test Plan:
- Reset, then load_start. Stream 16 words data = 0x11*i with ld_valid held high. Required: ld_done = 1 after the 16th handshake, ld_count = 16, checksum = 0xF8, cpu_hold returns to 0 one cycle after load completes.
- Load with ld_valid toggling every other cycle. Required: only handshaken words are written; RAM[5] = 0x55; ld_count = 16 and ld_done = 1 after 32 cycles of stimulus.
- Abort after 5 words. Required: ld_done = 0, ld_count = 5, checksum = 0xAA, FSM in IDLE; RAM[0..4] = 0x00..0x44 and RAM[5] is unchanged.
- During a load, drive cpu_we = 1, addr 3, wdata 0xEE. Required: write ignored. After the load, read cpu_addr = 3: cpu_rdata = 0x33 one cycle later.
- rb_start with rb_ready held low 3 cycles per word. Required: rb_data sequence 0x00, 0x11 … 0xFF in order, stable while stalled; rb_valid drops after the 16th handshake.
- Assert reset low mid-load, e.g. after 7 words. Required: all outputs 0 asynchronously and FSM in IDLE. After release, a new load_start starts again at address 0.
